// File: rtl/snake_pkg.sv
// Shared game-status encoding for the snake controller, datapath and renderer,
// plus a width helper for parameter-sized counters.
package snake_pkg;

   localparam logic [1:0] GS_RESTART = 2'b00;
   localparam logic [1:0] GS_START   = 2'b01;
   localparam logic [1:0] GS_PLAY    = 2'b10;
   localparam logic [1:0] GS_DIE     = 2'b11;

   typedef enum logic [1:0] {
      ST_RESTART = GS_RESTART,
      ST_START   = GS_START,
      ST_PLAY    = GS_PLAY,
      ST_DIE     = GS_DIE
   } game_state_t;

   // $clog2 that never returns 0, so tiny parameters still yield a 1-bit counter.
   function automatic int clog2_min1(input int x);
      return (x > 1) ? $clog2(x) : 1;
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable period divider: tick is high in the cycle the count reaches limit,
// and the count restarts from 0 on the following edge.
module snake_tick_gen #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tick
);

   logic [W-1:0] cnt;

   // >= so that a limit lowered mid-count fires on the next cycle instead of wrapping.
   assign tick = en && !clr && (cnt >= limit);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: RESTART/START/PLAY/DIE status, move strobe, death blink,
// and the protect/slow reward timers.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int MOVE_PERIOD  = 12_500_000,
   parameter int SLOW_PERIOD  = 25_000_000,
   parameter int FLASH_PERIOD = 12_500_000,
   parameter int FLASH_COUNT  = 8,
   parameter int REWARD_MOVES = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_press,
   input  logic       hit_wall,
   input  logic       hit_body,
   input  logic       hit_mine,
   input  logic       get_protect,
   input  logic       get_slow,
   output logic [1:0] game_status,
   output logic       move_tick,
   output logic       die_flash,
   output logic       reward_protected,
   output logic       reward_slowly,
   output logic       speed_recover
);

   localparam int STEP_MAX = (SLOW_PERIOD > MOVE_PERIOD) ? SLOW_PERIOD : MOVE_PERIOD;
   localparam int STEP_W   = clog2_min1(STEP_MAX);
   localparam int FLASH_W  = clog2_min1(FLASH_PERIOD);
   localparam int TOG_W    = clog2_min1(FLASH_COUNT);
   localparam int RW_W     = clog2_min1(REWARD_MOVES + 1);

   localparam logic [STEP_W-1:0]  MOVE_LIM  = STEP_W'(MOVE_PERIOD - 1);
   localparam logic [STEP_W-1:0]  SLOW_LIM  = STEP_W'(SLOW_PERIOD - 1);
   localparam logic [FLASH_W-1:0] FLASH_LIM = FLASH_W'(FLASH_PERIOD - 1);
   localparam logic [TOG_W-1:0]   TOG_LAST  = TOG_W'(FLASH_COUNT - 1);
   localparam logic [RW_W-1:0]    RW_LOAD   = RW_W'(REWARD_MOVES);

   game_state_t state, state_next;
   logic        in_play, in_die, death;
   logic        step_tick, flash_tick, flash_last, tick_now;
   logic [TOG_W-1:0] tog_cnt;
   logic [RW_W-1:0]  prot_cnt, slow_cnt, prot_nxt, slow_nxt;
   logic             recover_nxt;

   assign in_play     = (state == ST_PLAY);
   assign in_die      = (state == ST_DIE);
   assign death       = hit_wall | hit_body | hit_mine;
   assign tick_now    = in_play && !death && step_tick;
   assign flash_last  = flash_tick && (tog_cnt == TOG_LAST);
   assign game_status = state;

   snake_tick_gen #(.W(STEP_W)) u_step (
      .clk   (clk),
      .rst   (rst),
      .clr   (!in_play),
      .en    (in_play),
      .limit (reward_slowly ? SLOW_LIM : MOVE_LIM),
      .tick  (step_tick)
   );

   snake_tick_gen #(.W(FLASH_W)) u_flash (
      .clk   (clk),
      .rst   (rst),
      .clr   (!in_die),
      .en    (in_die),
      .limit (FLASH_LIM),
      .tick  (flash_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_RESTART;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RESTART: state_next = ST_START;
         ST_START:   if (start_press) state_next = ST_PLAY;
         ST_PLAY:    if (death) state_next = ST_DIE;
         ST_DIE:     if (flash_last) state_next = ST_RESTART;
         default:    state_next = ST_RESTART;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         move_tick <= 1'b0;
         die_flash <= 1'b1;
         tog_cnt   <= '0;
      end else begin
         move_tick <= tick_now;
         if (!in_die) begin
            die_flash <= 1'b1;
            tog_cnt   <= '0;
         end else if (flash_last) begin
            die_flash <= 1'b1;
            tog_cnt   <= '0;
         end else if (flash_tick) begin
            die_flash <= ~die_flash;
            tog_cnt   <= tog_cnt + TOG_W'(1);
         end
      end
   end

   // A fresh reward load beats a same-edge decrement; death wipes both timers.
   always_comb begin
      prot_nxt    = prot_cnt;
      slow_nxt    = slow_cnt;
      recover_nxt = 1'b0;
      if (in_play) begin
         if (death) begin
            prot_nxt = '0;
            slow_nxt = '0;
         end else begin
            if (get_protect)                    prot_nxt = RW_LOAD;
            else if (tick_now && prot_cnt != '0) prot_nxt = prot_cnt - RW_W'(1);
            if (get_slow) begin
               slow_nxt = RW_LOAD;
            end else if (tick_now && slow_cnt != '0) begin
               slow_nxt    = slow_cnt - RW_W'(1);
               recover_nxt = (slow_cnt == RW_W'(1));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prot_cnt         <= '0;
         slow_cnt         <= '0;
         reward_protected <= 1'b0;
         reward_slowly    <= 1'b0;
         speed_recover    <= 1'b0;
      end else begin
         prot_cnt         <= prot_nxt;
         slow_cnt         <= slow_nxt;
         reward_protected <= (prot_nxt != '0);
         reward_slowly    <= (slow_nxt != '0);
         speed_recover    <= recover_nxt;
      end
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small periods; each step samples outputs
// 1 time unit after the rising edge and sets inputs for the next edge.
module tb_snake_game_ctrl;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start_press, hit_wall, hit_body, hit_mine, get_protect, get_slow;
   logic [1:0] game_status;
   logic       move_tick, die_flash, reward_protected, reward_slowly, speed_recover;
   int         checks   = 0;
   int         failures = 0;

   snake_game_ctrl #(
      .MOVE_PERIOD  (4),
      .SLOW_PERIOD  (8),
      .FLASH_PERIOD (2),
      .FLASH_COUNT  (4),
      .REWARD_MOVES (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start_press      (start_press),
      .hit_wall         (hit_wall),
      .hit_body         (hit_body),
      .hit_mine         (hit_mine),
      .get_protect      (get_protect),
      .get_slow         (get_slow),
      .game_status      (game_status),
      .move_tick        (move_tick),
      .die_flash        (die_flash),
      .reward_protected (reward_protected),
      .reward_slowly    (reward_slowly),
      .speed_recover    (speed_recover)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check2({tag, "_status"}, game_status, GS_RESTART);
      check1({tag, "_tick"}, move_tick, 1'b0);
      check1({tag, "_flash"}, die_flash, 1'b1);
      check1({tag, "_prot"}, reward_protected, 1'b0);
      check1({tag, "_slow"}, reward_slowly, 1'b0);
      check1({tag, "_recover"}, speed_recover, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start_press = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
      hit_mine = 1'b0; get_protect = 1'b0; get_slow = 1'b0;
      step();
      step();
      check_reset_values("reset");

      // Idle after reset: one RESTART cycle (the cycle above), then START held.
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check2("idle_status", game_status, GS_START);
         check1("idle_tick", move_tick, 1'b0);
         check1("idle_flash", die_flash, 1'b1);
      end

      // Start: PLAY entry is cycle 0, ticks on cycles 4, 8, 12.
      start_press = 1'b1;
      step();
      start_press = 1'b0;
      check2("play_entry", game_status, GS_PLAY);
      check1("play_tick0", move_tick, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         step();
         check2("play_status", game_status, GS_PLAY);
         check1("play_tick", move_tick, (k % 4) == 0);
      end

      // Cycle 15 would produce the tick on cycle 16; the collision suppresses it.
      hit_body = 1'b1;
      step();
      check2("die_entry", game_status, GS_DIE);
      check1("die_tick_suppressed", move_tick, 1'b0);
      check1("die_flash0", die_flash, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         step();
         start_press = 1'b0;
         check2("die_status", game_status, GS_DIE);
         check1("die_tick", move_tick, 1'b0);
         check1("die_flash", die_flash, ((k / 2) % 2) == 0);
         if (k == 3) start_press = 1'b1;
      end
      step();
      hit_body = 1'b0;
      check2("die_to_restart", game_status, GS_RESTART);
      check1("restart_flash", die_flash, 1'b1);
      step();
      check2("restart_to_start", game_status, GS_START);

      // Slow reward taken on PLAY cycle 0: ticks at 8, 16, 24, then back to period 4.
      start_press = 1'b1;
      step();
      start_press = 1'b0;
      check2("slow_play_entry", game_status, GS_PLAY);
      check1("slow_before", reward_slowly, 1'b0);
      get_slow = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         step();
         get_slow = 1'b0;
         check1("slow_tick", move_tick, (k == 8) || (k == 16) || (k == 24) || (k == 28));
         check1("slow_active", reward_slowly, (k >= 1) && (k <= 23));
         check1("slow_recover", speed_recover, k == 24);
      end

      // Protect loaded on the same edge as the cycle-32 tick, reloaded before cycle 42.
      for (int k = 29; k <= 53; k++) begin
         step();
         check1("prot_tick", move_tick, (k % 4) == 0);
         check1("prot_active", reward_protected, (k >= 32) && (k <= 51));
         check1("prot_no_slow", reward_slowly, 1'b0);
         get_protect = (k == 31) || (k == 41);
      end

      // Reward pickup coincident with death: death wins.
      get_slow = 1'b1;
      get_protect = 1'b1;
      hit_mine = 1'b1;
      step();
      get_slow = 1'b0;
      get_protect = 1'b0;
      hit_mine = 1'b0;
      check2("mine_die", game_status, GS_DIE);
      check1("mine_no_slow", reward_slowly, 1'b0);
      check1("mine_no_prot", reward_protected, 1'b0);
      check1("mine_tick", move_tick, 1'b0);

      // Reset in the middle of the blink.
      step();
      step();
      check1("mid_die_flash", die_flash, 1'b0);
      rst = 1'b1;
      step();
      check_reset_values("rst_die");
      rst = 1'b0;
      step();
      check2("rst_die_start", game_status, GS_START);

      // Reset while both rewards are active.
      start_press = 1'b1;
      step();
      start_press = 1'b0;
      get_slow = 1'b1;
      get_protect = 1'b1;
      step();
      get_slow = 1'b0;
      get_protect = 1'b0;
      check1("rw_slow_on", reward_slowly, 1'b1);
      check1("rw_prot_on", reward_protected, 1'b1);
      step();
      rst = 1'b1;
      step();
      check_reset_values("rst_reward");
      rst = 1'b0;
      step();
      check2("rst_reward_start", game_status, GS_START);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
